// File: rtl/rr_arbiter_4req_pkg.sv
// Shared constants and types for the four-requester round-robin arbiter.
// Pure declarations; no latency and no backpressure of its own.
// Provides the pointer type, the reset pointer and a one-hot to index helper.
package rr_arbiter_4req_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] ptr_t;

  // Pointer value after reset: req0 is the first candidate searched.
  localparam ptr_t RST_PTR = 2'd3;

  function automatic ptr_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    ptr_t idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = ptr_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4req_if.sv
// Request/grant bundle between four agents and the round-robin arbiter.
// Wires only; no latency and no backpressure of its own.
// slave modport faces the arbiter, master modport faces the requesters.
interface rr_arbiter_4req_if;

  logic req0;
  logic req1;
  logic req2;
  logic req3;
  logic gnt0;
  logic gnt1;
  logic gnt2;
  logic gnt3;

  modport master (
    output req0, req1, req2, req3,
    input  gnt0, gnt1, gnt2, gnt3
  );

  modport slave (
    input  req0, req1, req2, req3,
    output gnt0, gnt1, gnt2, gnt3
  );

endinterface

// File: rtl/rr_arbiter_4req_prio_pick.sv
// Rotating priority encoder: first asserted request after last, wrapping.
// Purely combinational, zero latency.
// No backpressure; valid is low when no request is asserted.
module rr_prio_pick
  import rr_arbiter_4req_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  ptr_t               last,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  ptr_t cand;

  // Candidate i+1 positions after last; 2-bit arithmetic gives the wrap for free.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = last;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = last + ptr_t'(i + 1);
      if (!valid && req[cand]) begin
        winner[cand] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4req.sv
// Four-requester round-robin arbiter with registered one-hot grants.
// One cycle from sampled request to grant; re-arbitrates every cycle.
// No backpressure: a grant lasts one cycle and a dropped request loses it next edge.
module rr_arbiter_4req
  import rr_arbiter_4req_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rr_arbiter_4req_if.slave  bus
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] winner;
  logic               valid;
  ptr_t               last;

  assign req = {bus.req3, bus.req2, bus.req1, bus.req0};

  rr_prio_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .valid  (valid)
  );

  // An idle cycle clears the grant but keeps the pointer where it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt  <= '0;
      last <= RST_PTR;
    end else begin
      gnt <= winner;
      if (valid) last <= onehot_to_idx(winner);
    end
  end

  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];
  assign bus.gnt2 = gnt[2];
  assign bus.gnt3 = gnt[3];

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// Self-checking bench for rr_arbiter_4req: directed scenarios plus a randomized
// run compared against a pointer-and-modulo model of round-robin arbitration.
module tb_rr_arbiter_4req;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   mlast;
  logic [3:0] mexp;

  rr_arbiter_4req_if bus ();

  rr_arbiter_4req dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] get_gnt();
    return {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};
  endfunction

  task automatic set_req(input logic [3:0] r);
    bus.req0 = r[0];
    bus.req1 = r[1];
    bus.req2 = r[2];
    bus.req3 = r[3];
  endtask

  // Reference: scan last+1 .. last+4 modulo 4, first requester wins.
  function automatic int model_pick(input logic [3:0] r, input int last);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (last + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Drive r, let one rising edge sample it, advance the model, settle 1 unit.
  task automatic tick(input logic [3:0] r);
    int w;
    set_req(r);
    @(posedge clk);
    if (reset) begin
      mlast = 3;
      mexp  = 4'b0000;
    end else begin
      w = model_pick(r, mlast);
      if (w < 0) begin
        mexp = 4'b0000;
      end else begin
        mexp  = 4'b0001 << w;
        mlast = w;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(4'b0000);
    mlast = 3;
    #10;
    checks++;
    if (get_gnt() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: gnt=%b expected 0000", get_gnt());
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(4'b0000);
      checks++;
      if (get_gnt() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: gnt=%b expected 0000", i, get_gnt());
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_tab [5];
    exp_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      tick(4'b1111);
      checks++;
      if (get_gnt() !== exp_tab[i]) begin
        errors++;
        $display("FAIL rotation[%0d]: gnt=%b expected %b", i, get_gnt(), exp_tab[i]);
      end
    end
  endtask

  task automatic test_lone();
    for (int i = 0; i < 4; i++) begin
      tick(4'b0100);
      checks++;
      if (get_gnt() !== 4'b0100) begin
        errors++;
        $display("FAIL lone_req2[%0d]: gnt=%b expected 0100", i, get_gnt());
      end
    end
    tick(4'b0000);
    checks++;
    if (get_gnt() !== 4'b0000) begin
      errors++;
      $display("FAIL lone_drop: gnt=%b expected 0000", get_gnt());
    end
  endtask

  task automatic test_wrap();
    tick(4'b1000);
    checks++;
    if (get_gnt() !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_setup: gnt=%b expected 1000", get_gnt());
    end
    tick(4'b1001);
    checks++;
    if (get_gnt() !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_to_0: gnt=%b expected 0001", get_gnt());
    end
    tick(4'b1001);
    checks++;
    if (get_gnt() !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_back_3: gnt=%b expected 1000", get_gnt());
    end
  endtask

  task automatic test_async_reset();
    tick(4'b1111);
    tick(4'b1111);
    checks++;
    if (get_gnt() !== 4'b0010) begin
      errors++;
      $display("FAIL areset_pre: gnt=%b expected 0010", get_gnt());
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (get_gnt() !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate: gnt=%b expected 0000", get_gnt());
    end
    tick(4'b1111);
    checks++;
    if (get_gnt() !== 4'b0000) begin
      errors++;
      $display("FAIL areset_held: gnt=%b expected 0000", get_gnt());
    end
    reset = 1'b0;
    tick(4'b1111);
    checks++;
    if (get_gnt() !== 4'b0001) begin
      errors++;
      $display("FAIL areset_release: gnt=%b expected 0001", get_gnt());
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] g;
    int         waits [4];
    r = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) waits[i] = 0;
    for (int n = 0; n < 1000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      tick(r);
      g = get_gnt();
      checks++;
      if (g !== mexp) begin
        errors++;
        $display("FAIL rand_model[%0d]: gnt=%b expected %b req=%b", n, g, mexp, r);
      end
      checks++;
      if (!$onehot0(g)) begin
        errors++;
        $display("FAIL rand_onehot[%0d]: gnt=%b expected one-hot or zero", n, g);
      end
      checks++;
      if ((g & ~r) !== 4'b0000) begin
        errors++;
        $display("FAIL rand_nonreq[%0d]: gnt=%b req=%b expected no grant outside req", n, g, r);
      end
      for (int b = 0; b < 4; b++) begin
        if (!r[b] || g[b]) waits[b] = 0;
        else waits[b]++;
        checks++;
        if (waits[b] > 3) begin
          errors++;
          $display("FAIL rand_starve[%0d] req%0d: waited %0d edges expected at most 3", n, b, waits[b]);
        end
      end
    end
    set_req(4'b0000);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mexp   = 4'b0000;
    test_reset();
    test_rotation();
    test_lone();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4req.md
Name: rr_arbiter_4req

Overview:
- Four-requester round-robin arbiter with registered one-hot grants.
- Used wherever four agents share one resource, for example NoC router output ports.
- Re-arbitrates every clock cycle. Priority rotates to the requester after the most recently granted one, so any continuously asserted request is served within 4 cycles.

Parameters:
- None exposed. Fixed internal constant NUM_REQ = 4, the number of requesters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req3  input  1  request from agent 3.
- req2  input  1  request from agent 2.
- req1  input  1  request from agent 1.
- req0  input  1  request from agent 0.
- gnt3  output  1  registered grant to agent 3.
- gnt2  output  1  registered grant to agent 2.
- gnt1  output  1  registered grant to agent 1.
- gnt0  output  1  registered grant to agent 0.

Behaviour:
- State:
  - gnt[3:0], registered outputs.
  - last[1:0], index of the most recently granted requester.
- Reset (asynchronous, active-high):
  - gnt = 4'b0000 immediately.
  - last = 3, so req0 has top priority first.
  - Held while reset is high.
  - Reset asserted mid-operation drops every grant at once and restores the pointer.
- Each rising clk edge with reset low:
  - Sample req[3:0].
  - Search order is last+1, last+2, last+3, last+4, modulo 4 (wrap 3 -> 0).
  - The first asserted request in that order wins.
  - gnt is loaded with its one-hot bit, and last is loaded with its index.
- Latency: a request sampled at edge k produces a grant visible after edge k (one register stage). Grants are never combinational from req.
- If no request is asserted: gnt = 0 and last is unchanged.
- Invariant: gnt is always one-hot or zero; never two grants at once.
- A lone continuous requester keeps its grant every cycle. The search wraps all the way back to itself as its 4th candidate.
- There is no grant hold or lock. Each cycle is an independent arbitration, so with all requests held, the grant rotates every cycle.
- Deasserting a request removes its grant at the next edge.
- A request asserted together with others is not guaranteed the grant that cycle.
- Outputs change only on a clk edge or on reset assertion.

Decomposition:
- Shared package:
  - NUM_REQ = 4.
  - Pointer typedef: 2-bit index.
  - Reset pointer value = 3.
- One natural sub-module: rr_prio_pick.
  - Combinational rotate-and-priority-encode.
  - Inputs: req[3:0], last[1:0].
  - Outputs: winner one-hot[3:0] plus a valid flag.
- Top level holds only the gnt and last registers, the async reset, and the scalar port bit-mapping.

Test Plan:
- Hold reset high 10 time units with all req=0 -> all gnt=0. Releasing reset with no requests -> all gnt stay 0 and the pointer remains 3.
- After reset, assert req0..req3 all =1 on a clock edge and hold for 5 cycles -> grants after successive edges are gnt0, gnt1, gnt2, gnt3, gnt0, each one-hot.
- Only req2=1, held 4 cycles -> gnt2=1 every cycle. Drop req2 -> gnt2=0 after the next edge.
- Last grant gnt3, then req0=req3=1 -> gnt0 (wrap-around). Next cycle, same requests -> gnt3.
- Assert reset asynchronously mid-rotation while gnt1=1 -> all gnt=0 immediately, without a clock edge. Release reset with all requests held -> first grant is gnt0.
- Random req patterns for 1000 cycles with a scoreboard:
  - grant is one-hot or zero;
  - a grant is never given to a non-requester;
  - every continuously held request is granted within 4 cycles.
